// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the data-side load/store unit.
//   lsu_size_e  - access size encoding as presented on req_size
//   lsu_state_e - bus sequencing FSM states
//   LSU_TIMEOUT_DEFAULT - default bus watchdog limit in cycles
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } lsu_size_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BUS_RD  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_BUS_WR  = 3'd3,
    ST_RESP    = 3'd4
  } lsu_state_e;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational lane steering for the load/store unit.
// Ports:
//   size       in  access size
//   is_signed  in  sign-extend sub-word loads
//   addr_lo    in  byte offset within the word
//   wdata      in  right-justified store data
//   rdata      in  raw bus read word
//   byteenable out lane enables (lane i = byte offset i)
//   wdata_rep  out store data replicated across lanes
//   misaligned out access cannot be issued (misaligned or reserved size)
//   rdata_ext  out aligned and extended load data
module lsu_lane
  import lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic        is_signed,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] wdata_rep,
  output logic        misaligned,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    byteenable = 4'b0000;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    rdata_ext  = shifted;
    case (size)
      SZ_BYTE: begin
        byteenable = 4'b0001 << addr_lo;
        wdata_rep  = {4{wdata[7:0]}};
        rdata_ext  = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
        rdata_ext  = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        byteenable = 4'b1111;
        misaligned = |addr_lo;
      end
      default: begin
        // reserved size is rejected the same way as a misaligned access
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-side memory port. Turns one core load/store request
// into a single Avalon-MM transaction and returns extended load data.
// Optional feature macro: LSU_TIMEOUT_EN (bus watchdog of TIMEOUT_CYCLES).
// Ports:
//   clk, reset (sync, active-low)
//   req_*   core request: valid/write/size/signed/addr/wdata, req_ready out
//   resp_*  one-cycle completion: valid, rdata, err
//   avm_*   Avalon-MM master: address/read/write/byteenable/writedata out,
//           waitrequest/readdata/readdatavalid in
//
// state      | meaning
// ST_IDLE    | ready for a request
// ST_BUS_RD  | read command on the bus, held while waitrequest
// ST_RD_WAIT | read accepted, waiting for readdatavalid
// ST_BUS_WR  | write command on the bus, held while waitrequest
// ST_RESP    | one-cycle response to the core
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  lsu_state_e  state_q, state_d;
  lsu_size_e   size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        timeout;

  lsu_size_e   lane_size;
  logic        lane_signed;
  logic [31:0] lane_addr;
  logic [31:0] lane_wdata_in;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic        lane_misaligned;
  logic [31:0] lane_rdata;

  // In IDLE the lane logic checks the live request; afterwards it works on
  // the latched copy so one instance serves both accept and data phases.
  always_comb begin
    if (state_q == ST_IDLE) begin
      lane_size     = lsu_size_e'(req_size);
      lane_signed   = req_signed;
      lane_addr     = req_addr;
      lane_wdata_in = req_wdata;
    end else begin
      lane_size     = size_q;
      lane_signed   = signed_q;
      lane_addr     = addr_q;
      lane_wdata_in = wdata_q;
    end
  end

  lsu_lane u_lane (
    .size       (lane_size),
    .is_signed  (lane_signed),
    .addr_lo    (lane_addr[1:0]),
    .wdata      (lane_wdata_in),
    .rdata      (avm_readdata),
    .byteenable (lane_be),
    .wdata_rep  (lane_wdata),
    .misaligned (lane_misaligned),
    .rdata_ext  (lane_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (lane_misaligned) state_d = ST_RESP;
          else if (req_write)  state_d = ST_BUS_WR;
          else                 state_d = ST_BUS_RD;
        end
      end
      ST_BUS_RD: begin
        if (!avm_waitrequest) state_d = ST_RD_WAIT;
        else if (timeout)     state_d = ST_RESP;
      end
      ST_BUS_WR: begin
        if (!avm_waitrequest || timeout) state_d = ST_RESP;
      end
      ST_RD_WAIT: begin
        if (avm_readdatavalid || timeout) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            size_q   <= lsu_size_e'(req_size);
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            err_q    <= lane_misaligned;
          end
        end
        ST_RD_WAIT: begin
          if (avm_readdatavalid) rdata_q <= lane_rdata;
          else if (timeout)      err_q   <= 1'b1;
        end
        ST_BUS_RD, ST_BUS_WR: begin
          if (avm_waitrequest && timeout) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             in_bus;

  assign in_bus = (state_q == ST_BUS_RD) || (state_q == ST_BUS_WR) ||
                  (state_q == ST_RD_WAIT);

  // Restarts on every state change so BUS_RD and RD_WAIT each get a full
  // budget; fires on the last cycle so RESP follows TIMEOUT_CYCLES later.
  always_ff @(posedge clk) begin
    if (!reset)                tmo_cnt_q <= '0;
    else if (state_d != state_q) tmo_cnt_q <= '0;
    else if (in_bus)           tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign timeout = in_bus && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  logic cmd_active;
  assign cmd_active = (state_q == ST_BUS_RD) || (state_q == ST_BUS_WR);

  assign req_ready      = reset && (state_q == ST_IDLE);
  assign resp_valid     = (state_q == ST_RESP);
  assign resp_err       = (state_q == ST_RESP) && err_q;
  assign resp_rdata     = (state_q == ST_RESP) ? rdata_q : '0;
  assign avm_read       = (state_q == ST_BUS_RD);
  assign avm_write      = (state_q == ST_BUS_WR);
  assign avm_address    = cmd_active ? {addr_q[31:2], 2'b00} : '0;
  assign avm_byteenable = cmd_active ? lane_be : '0;
  assign avm_writedata  = (state_q == ST_BUS_WR) ? lane_wdata : '0;

endmodule
